// File: rtl/localization_pkg.sv
// localization_pkg: types and constants shared by the localization pipeline
package localization_pkg;
  typedef struct packed {
    logic signed [15:0] y;
    logic signed [15:0] x;
  } dir_vec_t;
  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} acc_state_t;
  localparam logic [15:0] PI_Q13     = 16'h6488;
  localparam logic [15:0] TWO_PI_Q13 = 16'hC910;
endpackage

// File: rtl/weighted_vec_mac.sv
// weighted_vec_mac: one-axis stage-1 product of a 6.10 component and an unsigned 3.13 magnitude, zeroed when gated off
// Ports: clk_in/rst_in clock and sync reset; i_en loads a new product; i_gate keeps (1) or zeroes (0) it;
//        i_val signed component; i_mag unsigned magnitude; o_prod registered signed 33-bit product
module weighted_vec_mac (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               i_en,
  input  logic               i_gate,
  input  logic signed [15:0] i_val,
  input  logic        [15:0] i_mag,
  output logic signed [32:0] o_prod
);
  logic signed [32:0] w_a, w_b;
  assign w_a = 33'(i_val);
  assign w_b = 33'($signed({1'b0, i_mag}));
  always_ff @(posedge clk_in)
    if (rst_in) o_prod <= '0;
    else if (i_en) o_prod <= i_gate ? w_a * w_b : '0;
endmodule

// File: rtl/direction_accumulator.sv
// direction_accumulator: magnitude-weighted, bin-gated per-frame sum of direction vectors with valid/ready output
// Ports: clk_in/rst_in clock and sync reset;
//        vec_valid_in/vec_ready_out/vector_in({y,x} 6.10)/mag_in(3.13)/bin_in/last_in bin stream in;
//        dir_valid_out/dir_ready_in/dir_out({y,x} saturated)/count_out(contributing bins) frame result out
module direction_accumulator
  import localization_pkg::*;
#(
  parameter int          BIN_W      = 10,
  parameter int          BIN_LO     = 4,
  parameter int          BIN_HI     = 200,
  parameter logic [15:0] MAG_THRESH = 16'h0200,
  parameter int          ACC_W      = 48,
  parameter int          OUT_SHIFT  = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             vec_valid_in,
  output logic             vec_ready_out,
  input  logic [31:0]      vector_in,
  input  logic [15:0]      mag_in,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             last_in,
  output logic             dir_valid_out,
  input  logic             dir_ready_in,
  output logic [31:0]      dir_out,
  output logic [BIN_W:0]   count_out
);
  acc_state_t              r_state, w_next;
  logic                    r_v1, r_c1, r_l1, r_valid, r_ready, w_acc, w_gate;
  logic signed [32:0]      w_px, w_py;
  logic signed [ACC_W-1:0] r_acc_x, r_acc_y, w_sum_x, w_sum_y;
  logic [BIN_W:0]          r_cnt, w_cnt, r_count;
  dir_vec_t                w_vec, r_dir;

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> OUT_SHIFT;
    return (s > ACC_W'(32767)) ? 16'sh7FFF : (s < -ACC_W'(32768)) ? 16'sh8000 : s[15:0];
  endfunction

  assign w_vec  = vector_in;
  assign w_acc  = vec_valid_in && vec_ready_out;
  assign w_gate = bin_in >= BIN_W'(BIN_LO) && bin_in <= BIN_W'(BIN_HI) && mag_in >= MAG_THRESH;

  weighted_vec_mac u_mac_x (.clk_in(clk_in), .rst_in(rst_in), .i_en(w_acc), .i_gate(w_gate),
                            .i_val(w_vec.x), .i_mag(mag_in), .o_prod(w_px));
  weighted_vec_mac u_mac_y (.clk_in(clk_in), .rst_in(rst_in), .i_en(w_acc), .i_gate(w_gate),
                            .i_val(w_vec.y), .i_mag(mag_in), .o_prod(w_py));

  // Stage-2 sums include the term currently in stage 1 so the last bin lands in the latched result.
  assign w_sum_x = r_acc_x + ACC_W'(w_px);
  assign w_sum_y = r_acc_y + ACC_W'(w_py);
  assign w_cnt   = (r_c1 && ~&r_cnt) ? r_cnt + 1'b1 : r_cnt;

  always_comb
    w_next = (r_state == ACCUM && w_acc && last_in) ? FLUSH :
             (r_state == FLUSH && r_v1 && r_l1)     ? HOLD  :
             (r_state == HOLD && dir_ready_in)      ? ACCUM : r_state;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ACCUM;
      r_v1    <= 1'b0;
      r_c1    <= 1'b0;
      r_l1    <= 1'b0;
      r_acc_x <= '0;
      r_acc_y <= '0;
      r_cnt   <= '0;
      r_dir   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_valid <= w_next == HOLD;
      r_ready <= w_next == ACCUM;
      r_v1    <= w_acc;
      r_c1    <= w_acc && w_gate;
      r_l1    <= w_acc && last_in;
      if (r_v1) begin
        r_acc_x <= r_l1 ? '0 : w_sum_x;
        r_acc_y <= r_l1 ? '0 : w_sum_y;
        r_cnt   <= r_l1 ? '0 : w_cnt;
      end
      if (r_v1 && r_l1) begin
        r_dir   <= {sat16(w_sum_y), sat16(w_sum_x)};
        r_count <= w_cnt;
      end
    end
  end

  assign vec_ready_out = r_ready;
  assign dir_valid_out = r_valid;
  assign dir_out       = r_dir;
  assign count_out     = r_count;
endmodule

// File: tb/tb_direction_accumulator.sv
// tb_direction_accumulator: table-driven scoreboard bench for two accumulators (OUT_SHIFT 16 and 0)
module tb_direction_accumulator;
  typedef struct {
    logic [15:0] x, y, mag;
    logic [9:0]  bin;
    logic        last;
    int          bp;
    int          exp_cnt;
  } vec_t;
  typedef struct {
    logic [31:0] d16, d0;
    int          cnt;
  } exp_t;

  logic        clk = 0, rst = 1, vec_valid = 0, last = 0, dir_ready = 0;
  logic [31:0] vector = 0;
  logic [15:0] mag = 0;
  logic [9:0]  bin = 0;
  logic        rdy, rdy_s, val, val_s;
  logic [31:0] dout, dout_s;
  logic [10:0] cnt, cnt_s;

  int     tests = 0, fails = 0;
  longint mx = 0, my = 0;
  vec_t   tbl[$];
  exp_t   sb[$];

  always #5 clk = ~clk;

  direction_accumulator dut (
    .clk_in(clk), .rst_in(rst), .vec_valid_in(vec_valid), .vec_ready_out(rdy),
    .vector_in(vector), .mag_in(mag), .bin_in(bin), .last_in(last),
    .dir_valid_out(val), .dir_ready_in(dir_ready), .dir_out(dout), .count_out(cnt));

  direction_accumulator #(.OUT_SHIFT(0)) dut_s (
    .clk_in(clk), .rst_in(rst), .vec_valid_in(vec_valid), .vec_ready_out(rdy_s),
    .vector_in(vector), .mag_in(mag), .bin_in(bin), .last_in(last),
    .dir_valid_out(val_s), .dir_ready_in(dir_ready), .dir_out(dout_s), .count_out(cnt_s));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(input longint v, input int sh);
    longint s = v >>> sh;
    return s > 32767 ? 16'h7FFF : s < -32768 ? 16'h8000 : s[15:0];
  endfunction

  function automatic void add(input logic [15:0] x, y, m, input logic [9:0] b,
                              input logic l, input int bp, input int ec);
    vec_t r;
    r.x = x; r.y = y; r.mag = m; r.bin = b; r.last = l; r.bp = bp; r.exp_cnt = ec;
    tbl.push_back(r);
  endfunction

  task automatic send(input vec_t r, input bit push);
    int g = 0;
    exp_t e;
    @(negedge clk);
    while (!rdy && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", rdy, 1);
    vec_valid = 1; vector = {r.y, r.x}; mag = r.mag; bin = r.bin; last = r.last; dir_ready = 1;
    @(posedge clk);
    if (r.bin >= 4 && r.bin <= 200 && r.mag >= 16'h0200) begin
      mx += longint'($signed(r.x)) * longint'(r.mag);
      my += longint'($signed(r.y)) * longint'(r.mag);
    end
    if (r.last) begin
      e.d16 = {sat(my, 16), sat(mx, 16)};
      e.d0  = {sat(my, 0), sat(mx, 0)};
      e.cnt = r.exp_cnt;
      if (push) sb.push_back(e);
      mx = 0; my = 0;
    end
    #1;
    if (r.last) vec_valid = 0;
  endtask

  task automatic recv(input int bp);
    int   lat = 0;
    exp_t e;
    dir_ready = (bp == 0);
    do begin
      @(negedge clk);
      lat++;
    end while (!val && lat < 20);
    chk("latency", lat, 2);
    chk("valid_s", val_s, 1);
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: result with no expected entry");
      return;
    end
    e = sb.pop_front();
    chk("dir16", dout, e.d16);
    chk("dir0", dout_s, e.d0);
    chk("count", cnt, e.cnt);
    chk("count_s", cnt_s, e.cnt);
    chk("ready_in_hold", rdy, 0);
    repeat (bp) begin
      @(negedge clk);
      chk("bp_valid", val, 1);
      chk("bp_dir", dout, e.d16);
      chk("bp_count", cnt, e.cnt);
      chk("bp_ready", rdy, 0);
    end
    dir_ready = 1;
    @(negedge clk);
    chk("valid_drop", val, 0);
    chk("ready_back", rdy, 1);
    dir_ready = 0;
  endtask

  initial begin
    vec_t r;
    add(16'h0400, 16'h0000, 16'h2000, 10, 1, 0, 1);
    add(16'h0400, 16'h0000, 16'h2000, 10, 0, 0, 0);
    add(16'hFC00, 16'h0000, 16'h2000, 20, 0, 0, 0);
    add(16'h0400, 16'h0000, 16'h2000, 30, 1, 0, 3);
    add(16'h0400, 16'h0000, 16'h2000,  2, 0, 0, 0);
    add(16'h0400, 16'h0000, 16'h0100, 10, 1, 10, 0);
    add(16'h0400, 16'h0400, 16'h0200,  4, 0, 0, 0);
    add(16'h0000, 16'hFC00, 16'h2000, 200, 0, 0, 0);
    add(16'h0400, 16'h0400, 16'h2000, 201, 0, 0, 0);
    add(16'h0400, 16'h0400, 16'h2000,  3, 0, 0, 0);
    add(16'h0400, 16'h0400, 16'h01FF, 50, 1, 3, 2);
    for (int i = 0; i < 4; i++) add(16'h7FFF, 16'h8000, 16'hFFFF, 10'(10 + i), i == 3, 0, 4);
    for (int i = 0; i < 4; i++) add(16'h8001, 16'h7FFF, 16'hFFFF, 10'(10 + i), i == 3, 0, 4);

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_valid", val, 0);
    chk("reset_dir", dout, 0);
    chk("reset_count", cnt, 0);
    chk("reset_ready", rdy, 1);
    chk("reset_valid_s", val_s, 0);
    chk("reset_ready_s", rdy_s, 1);

    foreach (tbl[i]) begin
      send(tbl[i], 1);
      if (tbl[i].last) recv(tbl[i].bp);
      else chk("midframe_valid", val, 0);
    end

    for (int i = 0; i < 2050; i++) begin
      r = '{16'h0000, 16'h0000, 16'h2000, 10'd10, i == 2049, 0, 2047};
      send(r, 1);
    end
    recv(0);

    r = '{16'h7FFF, 16'h7FFF, 16'h2000, 10'd10, 1'b1, 0, 0};
    send(r, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    begin
      bit seen = 0;
      repeat (6) begin
        @(negedge clk);
        seen |= val | val_s;
      end
      chk("flush_reset_no_result", seen, 0);
    end
    chk("flush_reset_dir", dout, 0);
    chk("flush_reset_ready", rdy, 1);

    r = '{16'h7FFF, 16'h7FFF, 16'h2000, 10'd10, 1'b0, 0, 0};
    send(r, 0);
    rst = 1; vec_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    mx = 0; my = 0;
    @(negedge clk);
    chk("midframe_reset_valid", val, 0);
    chk("midframe_reset_ready", rdy, 1);

    r = '{16'h0800, 16'h0C00, 16'h2000, 10'd100, 1'b1, 0, 1};
    send(r, 1);
    recv(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
